// File: rtl/pc_gen_ras.sv
// Program counter generator with a circular return-address stack.
// Ports: clk, rst (async high), stall, pc_src[2:0], imm, jpc, rd1, zero;
//        outputs pc (reg), pc_plus4, pc_next, ras_empty, ras_full (comb),
//        ras_ovf, ras_unf (registered single-cycle pulses).
module pc_gen_ras #(
  parameter int WIDTH = 32,
  parameter int RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [2:0]       pc_src,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] jpc,
  input  logic [WIDTH-1:0] rd1,
  input  logic             zero,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] pc_next,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf
);

  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  localparam logic [2:0] SRC_SEQ  = 3'b000;
  localparam logic [2:0] SRC_BEQ  = 3'b001;
  localparam logic [2:0] SRC_JR   = 3'b010;
  localparam logic [2:0] SRC_J    = 3'b011;
  localparam logic [2:0] SRC_BNE  = 3'b100;
  localparam logic [2:0] SRC_CALL = 3'b101;
  localparam logic [2:0] SRC_RET  = 3'b110;

  logic [WIDTH-1:0] stack [RAS_DEPTH];
  logic [AW-1:0]    top;
  logic [AW-1:0]    top_inc;
  logic [AW-1:0]    top_dec;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] btarget;
  logic             push;
  logic             pop;
  logic             commit;

  assign pc_plus4  = pc + WIDTH'(4);
  // imm is a word offset; the shift drops its top bits by design
  assign btarget   = pc_plus4 + (imm << 2);
  assign ras_empty = (count == '0);
  assign ras_full  = (count == DEPTH_C);
  assign top_inc   = top + AW'(1);
  assign top_dec   = top - AW'(1);
  assign commit    = !stall;

  always_comb begin
    pc_next = pc_plus4;
    push    = 1'b0;
    pop     = 1'b0;
    case (pc_src)
      SRC_SEQ:  pc_next = pc_plus4;
      SRC_BEQ:  pc_next = zero ? btarget : pc_plus4;
      SRC_JR:   pc_next = rd1;
      SRC_J:    pc_next = jpc;
      SRC_BNE:  pc_next = zero ? pc_plus4 : btarget;
      SRC_CALL: begin
        pc_next = jpc;
        push    = 1'b1;
      end
      SRC_RET: begin
        pc_next = ras_empty ? rd1 : stack[top];
        pop     = 1'b1;
      end
      default:  pc_next = pc_plus4;
    endcase
  end

  // Entries carry no reset; count alone defines validity.
  // The top pointer always advances on push, so a push into a full
  // stack lands on the oldest slot and becomes the new top.
  always_ff @(posedge clk) begin
    if (!rst && commit && push)
      stack[top_inc] <= pc_plus4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      top     <= '0;
      count   <= '0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else begin
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
      if (commit) begin
        pc <= pc_next;
        if (push) begin
          top <= top_inc;
          if (ras_full)
            ras_ovf <= 1'b1;
          else
            count <= count + CW'(1);
        end else if (pop) begin
          if (ras_empty) begin
            ras_unf <= 1'b1;
          end else begin
            top   <= top_dec;
            count <= count - CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: doc/pc_gen_ras.md
PC_GEN_RAS -- requirements
Module: pc_gen_ras

Interface
REQ-001 Parameter WIDTH, default 32, datapath/address width in bits (>= 8).
REQ-002 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >= 2).
REQ-003 Parameter RESET_PC, default 0 (WIDTH bits), PC value loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 stall  input  1  1 = hold PC and RAS this cycle.
REQ-007 pc_src  input  3  next-PC select (encoding in REQ-013).
REQ-008 imm  input  WIDTH  sign-extended branch offset, in words.
REQ-009 jpc  input  WIDTH  precomputed absolute jump target.
REQ-010 rd1  input  WIDTH  register-file read data (jr target / return fallback).
REQ-011 zero  input  1  ALU zero flag for the branch condition.
REQ-012 Outputs: pc (WIDTH, registered current PC); pc_plus4 (WIDTH, comb); pc_next (WIDTH, comb); ras_empty (1, comb); ras_full (1, comb); ras_ovf (1, registered); ras_unf (1, registered).

Function
REQ-013 pc_next SHALL be selected by pc_src:
- 000 seq: pc_plus4
- 001 beq: btarget if zero, else pc_plus4
- 010 jr: rd1
- 011 j: jpc
- 100 bne: btarget if !zero, else pc_plus4
- 101 call: jpc; push pc_plus4
- 110 ret: RAS top if non-empty, else rd1; pop
- 111 reserved: pc_plus4; no RAS action
REQ-014 pc_plus4 SHALL equal pc + 4, and btarget SHALL equal pc_plus4 + (imm << 2), both truncated to WIDTH bits (wrap-around, no carry out).
REQ-015 pc_next, pc_plus4, ras_empty and ras_full SHALL be purely combinational on the current inputs and state (zero-cycle latency).
REQ-016 On a rising edge with stall=0, pc SHALL load pc_next and the RAS action SHALL commit.
REQ-017 On a rising edge with stall=1, pc, RAS contents and RAS count SHALL be unchanged; ras_ovf and ras_unf SHALL load 0.
REQ-018 RAS SHALL be a LIFO with occupancy count 0..RAS_DEPTH; ras_empty = (count==0); ras_full = (count==RAS_DEPTH).
REQ-019 Push, not full: write pc_plus4 to the new top; count +1.
REQ-020 Push when full: overwrite the oldest entry circularly so the new value becomes top; count stays RAS_DEPTH; ras_ovf = 1 for the following cycle.
REQ-021 Pop, not empty: return the top entry; count -1.
REQ-022 Pop when empty: pc_next = rd1; count stays 0; ras_unf = 1 for the following cycle.
REQ-023 ras_ovf and ras_unf SHALL be 0 on any committed edge where the corresponding event does not occur; they are single-cycle pulses, not sticky.
REQ-024 At most one RAS operation per cycle; the encoding excludes simultaneous push and pop.
REQ-025 Branch/jump targets SHALL pass through unmodified; no alignment check or masking.

Reset
REQ-026 While rst=1, independent of clk: pc = RESET_PC, count = 0, ras_ovf = 0, ras_unf = 0.
REQ-027 RAS entry contents SHALL be don't-care after reset; a pop after reset SHALL behave as pop-when-empty.
REQ-028 Reset asserted mid-sequence (including during stall) SHALL abort pending state without a glitch to any intermediate PC; the first committed edge after deassertion uses pc = RESET_PC.

Verification
REQ-029 Reset, then 3 edges, pc_src=000, stall=0 -> pc = 0x0, 0x4, 0x8, 0xC.
REQ-030 pc=0x100, pc_src=001, imm=0xFFFFFFFE, zero=1 -> pc=0xFC; repeat with zero=0 -> pc=0x104; pc_src=100, zero=0, imm=3 -> pc=0x110.
REQ-031 pc=0x40, call jpc=0x200; then at pc=0x200, ret (rd1=0xDEAD) -> pc=0x200, then 0x44; ras_empty=1 afterwards.
REQ-032 RAS_DEPTH=4: 5 calls from pc=0x10,0x20,0x30,0x40,0x50 -> ras_ovf pulses once after the 5th; 4 rets yield 0x54,0x44,0x34,0x24; 5th ret yields rd1 and ras_unf=1 for one cycle.
REQ-033 stall=1 for 3 cycles with pc_src=101 -> pc, count and ras_full unchanged, ras_ovf=0; assert rst mid-stall -> pc=RESET_PC immediately, ras_empty=1.
REQ-034 pc=0xFFFFFFFC, pc_src=000 -> pc=0x0 (wrap); WIDTH=16 instance, pc=0xFFFC -> pc=0x0000.
